// File: rtl/pfb_ctrl_pkg.sv
// Shared types and default sizing for the pfb_multichannel frame sequencer.
package pfb_ctrl_pkg;

  localparam int CNT_W_DEF        = 32;
  localparam int WDOG_W_DEF       = 24;
  localparam int MAX_INFLIGHT_DEF = 2;
  localparam int INFL_W           = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pfb_stall_watchdog.sv
// Counts cycles with work outstanding but no handshake progress; raises a sticky
// stall flag and snapshots the kernel block status when the count reaches the limit.
module pfb_stall_watchdog
  import pfb_ctrl_pkg::*;
#(
  parameter int WDOG_W = WDOG_W_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              rearm,
  input  logic              clear,
  input  logic              active,
  input  logic [WDOG_W-1:0] limit,
  input  logic              blk,
  output logic              stall,
  output logic              stall_blk
);

  logic [WDOG_W-1:0] cnt_r;
  logic [WDOG_W-1:0] cnt_nxt_s;
  logic              hit_s;
  logic              stall_r;
  logic              stall_blk_r;

  // Next count: clear wins, otherwise saturating increment while active.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clear) begin
      cnt_nxt_s = '0;
    end else if (active && (cnt_r != '1)) begin
      cnt_nxt_s = cnt_r + WDOG_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Flag rises on the edge where the count reaches the limit; a zero limit never hits.
  assign hit_s = (limit != '0) && (cnt_nxt_s == limit);

  // Counter and sticky flag registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt_r       <= '0;
      stall_r     <= 1'b0;
      stall_blk_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      if (rearm) begin
        stall_r     <= 1'b0;
        stall_blk_r <= 1'b0;
      end else if (hit_s && !stall_r) begin
        stall_r     <= 1'b1;
        stall_blk_r <= blk;
      end else begin
        stall_r     <= stall_r;
        stall_blk_r <= stall_blk_r;
      end
    end
  end

  assign stall     = stall_r;
  assign stall_blk = stall_blk_r;

endmodule

// File: rtl/pfb_frame_sequencer.sv
// Drives the pfb_multichannel kernel through ap_ctrl_chain: one ap_start per frame,
// bounded overlap, backpressure-gated ap_continue, completion counting and watchdog.
module pfb_frame_sequencer
  import pfb_ctrl_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int WDOG_W       = WDOG_W_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [CNT_W-1:0]  cfg_num_frames,
  input  logic [WDOG_W-1:0] cfg_stall_limit,
  input  logic              ds_ready,
  output logic              k_ap_start,
  input  logic              k_ap_ready,
  input  logic              k_ap_done,
  input  logic              k_ap_idle,
  output logic              k_ap_continue,
  input  logic              k_blk,
  output logic              busy,
  output logic              seq_done,
  output logic [CNT_W-1:0]  frames_done,
  output logic              stall,
  output logic              stall_blk,
  output logic              err_underflow
);

  localparam logic [INFL_W-1:0] MAX_INFL_C = INFL_W'(MAX_INFLIGHT);
  localparam logic [INFL_W-1:0] INFL_ONE_C = INFL_W'(1);

  seq_state_e        state_r, state_nxt_s;
  logic [CNT_W-1:0]  num_frames_r, num_frames_nxt_s;
  logic [WDOG_W-1:0] stall_limit_r, stall_limit_nxt_s;
  logic [CNT_W-1:0]  started_r, started_nxt_s, started_inc_s;
  logic [CNT_W-1:0]  frames_done_r, frames_done_nxt_s;
  logic [INFL_W-1:0] inflight_r, inflight_nxt_s;
  logic              k_ap_start_r, k_ap_start_nxt_s;
  logic              k_ap_continue_r, k_ap_continue_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              seq_done_r, seq_done_nxt_s;
  logic              err_underflow_r, err_underflow_nxt_s;
  logic              start_hs_s, done_hs_s, accept_s, quota_left_s;

  assign start_hs_s    = k_ap_start_r & k_ap_ready;
  assign done_hs_s     = k_ap_done & k_ap_continue_r;
  assign accept_s      = (state_r == ST_IDLE) & cfg_start;
  assign started_inc_s = started_r + {{(CNT_W-1){1'b0}}, start_hs_s};

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; the frame-quota test sees this cycle's start handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_start) state_nxt_s = ST_RUN;
        else           state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (cfg_stop || ((num_frames_r != '0) && (started_inc_s == num_frames_r)))
          state_nxt_s = ST_DRAIN;
        else
          state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (!k_ap_start_r && (inflight_r == '0) && k_ap_idle) state_nxt_s = ST_IDLE;
        else                                                 state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of counters and registered outputs.
  always_comb begin
    num_frames_nxt_s    = num_frames_r;
    stall_limit_nxt_s   = stall_limit_r;
    started_nxt_s       = started_inc_s;
    frames_done_nxt_s   = frames_done_r + {{(CNT_W-1){1'b0}}, done_hs_s};
    inflight_nxt_s      = inflight_r;
    err_underflow_nxt_s = err_underflow_r;

    case ({start_hs_s, done_hs_s})
      2'b10: inflight_nxt_s = inflight_r + INFL_ONE_C;
      2'b01: begin
        if (inflight_r == '0) err_underflow_nxt_s = 1'b1;
        else                  inflight_nxt_s      = inflight_r - INFL_ONE_C;
      end
      default: inflight_nxt_s = inflight_r;
    endcase

    if (accept_s) begin
      num_frames_nxt_s    = cfg_num_frames;
      stall_limit_nxt_s   = cfg_stall_limit;
      started_nxt_s       = '0;
      frames_done_nxt_s   = '0;
      inflight_nxt_s      = '0;
      err_underflow_nxt_s = 1'b0;
    end else begin
      num_frames_nxt_s = num_frames_r;
    end

    quota_left_s = (num_frames_nxt_s == '0) || (started_nxt_s < num_frames_nxt_s);

    // A raised start is never withdrawn before ready, and always drops after acceptance.
    if (k_ap_start_r) begin
      k_ap_start_nxt_s = ~k_ap_ready;
    end else if ((state_nxt_s == ST_RUN) && (inflight_nxt_s < MAX_INFL_C) && quota_left_s) begin
      k_ap_start_nxt_s = 1'b1;
    end else begin
      k_ap_start_nxt_s = 1'b0;
    end

    k_ap_continue_nxt_s = ds_ready && (state_nxt_s != ST_IDLE);
    busy_nxt_s          = (state_nxt_s != ST_IDLE);
    seq_done_nxt_s      = (state_r == ST_DRAIN) && (state_nxt_s == ST_IDLE);
  end

  // Counter and output registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      num_frames_r    <= '0;
      stall_limit_r   <= '0;
      started_r       <= '0;
      frames_done_r   <= '0;
      inflight_r      <= '0;
      k_ap_start_r    <= 1'b0;
      k_ap_continue_r <= 1'b0;
      busy_r          <= 1'b0;
      seq_done_r      <= 1'b0;
      err_underflow_r <= 1'b0;
    end else begin
      num_frames_r    <= num_frames_nxt_s;
      stall_limit_r   <= stall_limit_nxt_s;
      started_r       <= started_nxt_s;
      frames_done_r   <= frames_done_nxt_s;
      inflight_r      <= inflight_nxt_s;
      k_ap_start_r    <= k_ap_start_nxt_s;
      k_ap_continue_r <= k_ap_continue_nxt_s;
      busy_r          <= busy_nxt_s;
      seq_done_r      <= seq_done_nxt_s;
      err_underflow_r <= err_underflow_nxt_s;
    end
  end

  pfb_stall_watchdog #(
    .WDOG_W (WDOG_W)
  ) u_watchdog (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .rearm     (accept_s),
    .clear     (start_hs_s | done_hs_s | (state_r == ST_IDLE)),
    .active    (busy_r & ((inflight_r != '0) | k_ap_start_r)),
    .limit     (stall_limit_r),
    .blk       (k_blk),
    .stall     (stall),
    .stall_blk (stall_blk)
  );

  assign k_ap_start    = k_ap_start_r;
  assign k_ap_continue = k_ap_continue_r;
  assign busy          = busy_r;
  assign seq_done      = seq_done_r;
  assign frames_done   = frames_done_r;
  assign err_underflow = err_underflow_r;

endmodule
